// File: rtl/clk_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl_if
// Purpose  : Divisor configuration handshake between a controller (master)
//            and the clock divider (slave).
// Signals  : cfg_valid  master -> slave  new divisor offered
//            cfg_div    master -> slave  requested divisor N (DIV_W bits)
//            cfg_ready  slave -> master  divisor can be accepted this cycle
//            cfg_err    slave -> master  one-cycle pulse: divisor rejected
// Revision : 1.0  initial release
// ============================================================================
interface clk_div_ctrl_if #(
  parameter int DIV_W = 16
);
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Purpose  : Programmable integer clock divider with glitch-free divisor
//            switching and period-aligned start/stop.
// Ports    : clk_in   input   source clock, all logic on its rising edge
//            reset    input   asynchronous active-high reset
//            en       input   run request, sampled only at period boundaries
//            cfg      slave   divisor handshake (clk_div_ctrl_if.slave)
//            clk_out  output  divided square wave, straight from a flop
//            tick     output  pulse on the last clk_in cycle of each period
//            busy     output  high whenever the divider is not stopped
// Revision : 1.0  initial release
// ============================================================================
module clk_div_ctrl #(
  parameter int FREC_BASE   = 100,
  parameter int FREC_SALIDA = 10,
  parameter int DIV_W       = 16
) (
  input  wire logic         clk_in,
  input  wire logic         reset,
  input  wire logic         en,
  clk_div_ctrl_if.slave     cfg,
  output logic              clk_out,
  output logic              tick,
  output logic              busy
);

  localparam int               DEF_DIV = FREC_BASE / FREC_SALIDA;
  localparam logic [DIV_W-1:0] C_DEF   = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] C_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] C_TWO   = DIV_W'(2);

  localparam logic [1:0] ST_STOP   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [DIV_W-1:0] cnt_q,     cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             clk_out_q, clk_out_d;
  logic             cfg_err_q, cfg_err_d;

  logic w_ready;
  logic w_boundary;
  logic w_accept;
  logic w_bad;
  logic w_good;

  // A divisor is only taken while no switch is outstanding, so at most one
  // pending divisor ever exists.
  assign w_ready    = (state_q != ST_SWITCH);
  // div_act_q >= 2 always, so the subtraction never wraps.
  assign w_boundary = (cnt_q == (div_act_q - C_ONE));
  assign w_accept   = cfg.cfg_valid && w_ready;
  assign w_bad      = w_accept && (cfg.cfg_div < C_TWO);
  assign w_good     = w_accept && !w_bad;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    cfg_err_d  = w_bad;

    case (state_q)
      ST_STOP: begin
        if (w_good) begin
          div_act_d = cfg.cfg_div;
        end
        if (en) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        if (w_boundary) begin
          cnt_d   = '0;
          state_d = en ? ST_RUN : ST_STOP;
          // Accepted on the boundary itself: nothing left of the old period
          // to protect, so the new divisor applies straight away.
          if (w_good) begin
            div_act_d = cfg.cfg_div;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
          if (w_good) begin
            div_pend_d = cfg.cfg_div;
            state_d    = ST_SWITCH;
          end
        end
      end

      ST_SWITCH: begin
        if (w_boundary) begin
          cnt_d     = '0;
          div_act_d = div_pend_q;
          state_d   = en ? ST_RUN : ST_STOP;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end

      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
      end
    endcase

    // Output level is precomputed from the next count/divisor so clk_out
    // comes straight from a flop and never glitches.
    clk_out_d = (state_d != ST_STOP) && (cnt_d < (div_act_d >> 1));
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= ST_STOP;
      cnt_q      <= '0;
      div_act_q  <= C_DEF;
      div_pend_q <= '0;
      clk_out_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      clk_out_q  <= clk_out_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign clk_out       = clk_out_q;
  assign tick          = (state_q != ST_STOP) && w_boundary;
  assign busy          = (state_q != ST_STOP);
  assign cfg.cfg_ready = w_ready;
  assign cfg.cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_ctrl
// Purpose  : Directed self-checking bench for clk_div_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_clk_div_ctrl;

  localparam int DIV_W = 16;

  logic clk_in;
  logic reset;
  logic en;
  logic clk_out;
  logic tick;
  logic busy;

  int errors = 0;
  int checks = 0;

  clk_div_ctrl_if #(.DIV_W(DIV_W)) cfg_if ();

  clk_div_ctrl #(
    .FREC_BASE  (100),
    .FREC_SALIDA(10),
    .DIV_W      (DIV_W)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .en     (en),
    .cfg    (cfg_if),
    .clk_out(clk_out),
    .tick   (tick),
    .busy   (busy)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check the running waveform for `cycles` cycles starting at count c0,
  // advancing one clk_in cycle after each check.
  task automatic seq(input string tag, input int n, input int c0, input int cycles);
    int c;
    for (int k = 0; k < cycles; k++) begin
      c = (c0 + k) % n;
      chk($sformatf("%s clk_out cnt=%0d", tag, c), clk_out, c < n / 2);
      chk($sformatf("%s tick cnt=%0d", tag, c), tick, c == n - 1);
      chk($sformatf("%s busy cnt=%0d", tag, c), busy, 1'b1);
      step();
    end
  endtask

  initial begin
    reset            = 1'b0;
    en               = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst clk_out", clk_out, 1'b0);
    chk("rst tick", tick, 1'b0);
    chk("rst cfg_err", cfg_if.cfg_err, 1'b0);
    step();
    reset = 1'b0;
    step();
    step();
    chk("idle busy", busy, 1'b0);
    chk("idle ready", cfg_if.cfg_ready, 1'b1);
    chk("idle clk_out", clk_out, 1'b0);

    // Default divisor 10: 5 high / 5 low, tick at cnt 9
    en = 1'b1;
    step();
    seq("def", 10, 0, 24);

    // Divisor 3 accepted at cnt 4; second offer during SWITCH ignored
    chk("sw ready cnt4", cfg_if.cfg_ready, 1'b1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 16'd3;
    step();
    cfg_if.cfg_valid = 1'b0;
    for (int c = 5; c < 10; c++) begin
      chk($sformatf("sw ready cnt=%0d", c), cfg_if.cfg_ready, 1'b0);
      chk($sformatf("sw clk_out cnt=%0d", c), clk_out, 1'b0);
      chk($sformatf("sw tick cnt=%0d", c), tick, c == 9);
      cfg_if.cfg_valid = (c == 6);
      cfg_if.cfg_div   = 16'd7;
      step();
    end
    cfg_if.cfg_valid = 1'b0;
    chk("n3 ready", cfg_if.cfg_ready, 1'b1);
    seq("n3", 3, 0, 9);

    // Divisor 10 offered on the boundary cycle applies to the next period
    step();
    step();
    chk("bnd tick", tick, 1'b1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 16'd10;
    step();
    chk("bnd ready", cfg_if.cfg_ready, 1'b1);
    chk("bnd clk_out", clk_out, 1'b1);

    // Divisor 1 rejected: one-cycle error, waveform untouched
    cfg_if.cfg_div = 16'd1;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("err pulse", cfg_if.cfg_err, 1'b1);
    chk("err ready", cfg_if.cfg_ready, 1'b1);
    step();
    chk("err clear", cfg_if.cfg_err, 1'b0);
    seq("err", 10, 2, 18);

    // en dropped at cnt 2: period completes, then stop
    seq("stp", 10, 0, 2);
    en = 1'b0;
    seq("stp", 10, 2, 8);
    chk("stopped busy", busy, 1'b0);
    chk("stopped clk_out", clk_out, 1'b0);
    chk("stopped tick", tick, 1'b0);
    step();
    step();
    chk("stopped busy2", busy, 1'b0);

    // Reset during SWITCH discards the pending divisor
    en = 1'b1;
    step();
    seq("pre", 10, 0, 3);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 16'd4;
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    step();
    chk("sw6 ready", cfg_if.cfg_ready, 1'b0);
    chk("sw6 busy", busy, 1'b1);
    #2 reset = 1'b1;
    en = 1'b0;
    #1;
    chk("arst busy", busy, 1'b0);
    chk("arst clk_out", clk_out, 1'b0);
    chk("arst tick", tick, 1'b0);
    chk("arst cfg_err", cfg_if.cfg_err, 1'b0);
    chk("arst ready", cfg_if.cfg_ready, 1'b1);
    reset = 1'b0;
    step();
    chk("post busy", busy, 1'b0);
    en = 1'b1;
    step();
    seq("post", 10, 0, 20);

    // Config in STOP: zero rejected, then N=2 gives 1 high / 1 low
    reset = 1'b1;
    #1 reset = 1'b0;
    en = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 16'd0;
    step();
    chk("stop err", cfg_if.cfg_err, 1'b1);
    chk("stop err busy", busy, 1'b0);
    cfg_if.cfg_div = 16'd2;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("stop cfg err", cfg_if.cfg_err, 1'b0);
    chk("stop cfg busy", busy, 1'b0);
    en = 1'b1;
    step();
    seq("n2", 2, 0, 6);

    // Full-width divisor loaded together with en
    reset = 1'b1;
    #1 reset = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 16'hFFFF;
    step();
    cfg_if.cfg_valid = 1'b0;
    seq("max", 65535, 0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
